// File: rtl/axi_wr_slave_if.sv
// AXI3 write-channel bundle (AW/W/B) between a write master and axi_wr_slave.
interface axi_wr_slave_if;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_wr_slave.sv
// AXI3 write responder: one transaction at a time, byte-strobed commits into a
// word-addressed RAM, one B response per transaction, combinational debug read port.
module axi_wr_slave #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  resetn,
    axi_wr_slave_if.slave         bus,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [31:0]           dbg_rdata
);
    localparam int unsigned WORDS = 1 << ADDR_WIDTH;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        W_HELD = 4'b0010,
        DATA   = 4'b0100,
        BRESP  = 4'b1000
    } state_t;

    state_t      state;
    logic        awready_q, wready_q, bvalid_q;
    logic [3:0]  bid_q, id_q;
    logic [1:0]  bresp_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q, cnt_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        err_q, past_q;
    logic [31:0] hold_data;
    logic [3:0]  hold_strb;
    logic        hold_last;

    logic [31:0] mem [WORDS];

    logic        aw_hs, w_hs, start;
    logic        c_fire, c_last, c_past, c_legal, c_we, c_err, c_err_acc, c_past_nxt;
    logic [31:0] c_addr, c_data, c_next_addr;
    logic [3:0]  c_strb;
    logic [2:0]  c_size;
    logic [1:0]  c_burst;
    logic [7:0]  c_len, c_cnt, c_cnt_nxt;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic        unused_ok;

    assign bus.awready = awready_q & resetn;
    assign bus.wready  = wready_q & resetn;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

    assign unused_ok = ^{bus.awlock, bus.awcache, bus.awprot, bus.wid};

    assign aw_hs = bus.awvalid & bus.awready;
    assign w_hs  = bus.wvalid & bus.wready;
    // A transaction starts when AW is accepted together with a beat (live or held)
    assign start = aw_hs & ((state == IDLE && w_hs) || state == W_HELD);

    always_comb begin
        c_fire  = 1'b0;
        c_addr  = addr_q;
        c_data  = bus.wdata;
        c_strb  = bus.wstrb;
        c_last  = bus.wlast;
        c_size  = size_q;
        c_burst = burst_q;
        c_len   = len_q;
        c_cnt   = cnt_q;
        c_past  = past_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    c_fire  = 1'b1;
                    c_addr  = bus.awaddr;
                    c_size  = bus.awsize;
                    c_burst = bus.awburst;
                    c_len   = bus.awlen;
                    c_cnt   = '0;
                    c_past  = 1'b0;
                end
            end
            W_HELD: begin
                if (start) begin
                    c_fire  = 1'b1;
                    c_addr  = bus.awaddr;
                    c_size  = bus.awsize;
                    c_burst = bus.awburst;
                    c_len   = bus.awlen;
                    c_cnt   = '0;
                    c_past  = 1'b0;
                    c_data  = hold_data;
                    c_strb  = hold_strb;
                    c_last  = hold_last;
                end
            end
            DATA:    c_fire = w_hs;
            default: c_fire = 1'b0;
        endcase

        // Beats past awlen (missing wlast) are swallowed without writing
        c_legal = (c_size <= 3'd2) && !c_burst[1] && !c_past &&
                  ((c_addr >> (ADDR_WIDTH + 2)) == (BASE_ADDR >> (ADDR_WIDTH + 2)));
        c_we      = c_fire && c_legal && resetn;
        c_err     = c_fire && (!c_legal || (c_last && (c_cnt < c_len)) ||
                               (!c_last && (c_cnt >= c_len)));
        c_err_acc = (start ? 1'b0 : err_q) | c_err;
        c_idx     = c_addr[ADDR_WIDTH+1:2];
        c_next_addr = (c_burst == 2'b01) ? c_addr + (32'd1 << c_size) : c_addr;
        c_cnt_nxt   = (c_cnt == 8'hFF) ? c_cnt : c_cnt + 8'd1;
        c_past_nxt  = c_past | (c_cnt >= c_len);
    end

    always_ff @(posedge clk) begin
        if (c_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (c_strb[i]) mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
            end
        end
    end

    assign dbg_rdata = mem[dbg_addr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
            err_q     <= 1'b0;
            past_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (c_fire) begin
            if (start) begin
                id_q    <= bus.awid;
                len_q   <= bus.awlen;
                size_q  <= bus.awsize;
                burst_q <= bus.awburst;
            end
            err_q  <= c_err_acc;
            addr_q <= c_next_addr;
            cnt_q  <= c_cnt_nxt;
            past_q <= c_past_nxt;
            if (c_last) begin
                state     <= BRESP;
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bid_q     <= start ? bus.awid : id_q;
                bresp_q   <= c_err_acc ? 2'b10 : 2'b00;
            end else begin
                state     <= DATA;
                awready_q <= 1'b0;
                wready_q  <= 1'b1;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    // Readies come up one cycle after reset release
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs) begin
                        id_q      <= bus.awid;
                        len_q     <= bus.awlen;
                        size_q    <= bus.awsize;
                        burst_q   <= bus.awburst;
                        addr_q    <= bus.awaddr;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        past_q    <= 1'b0;
                        state     <= DATA;
                        awready_q <= 1'b0;
                    end else if (w_hs) begin
                        hold_data <= bus.wdata;
                        hold_strb <= bus.wstrb;
                        hold_last <= bus.wlast;
                        state     <= W_HELD;
                        wready_q  <= 1'b0;
                    end
                end
                W_HELD, DATA: begin
                end
                BRESP: begin
                    if (bus.bready) begin
                        state     <= IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_slave.sv
// Randomized bench for axi_wr_slave against a transaction-level memory/response model.
module tb_axi_wr_slave;
    localparam int          AW    = 10;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [31:0]   dbg_rdata;

    axi_wr_slave_if bus ();

    axi_wr_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mm    [WORDS];
    logic [3:0]  known [WORDS];
    logic [31:0] td    [16];
    logic [3:0]  ts    [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_words(input int q[$]);
        logic [31:0] mask;
        foreach (q[j]) begin
            dbg_addr = q[j][AW-1:0];
            #1;
            for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{known[q[j]][b]}};
            if (known[q[j]] != 4'h0) check("ram_word", dbg_rdata & mask, mm[q[j]] & mask);
        end
        @(posedge clk); #1;
    endtask

    // Expected response and RAM effect of a transaction, straight from the protocol rules
    task automatic model_txn(input logic [31:0] addr, input int len, input int size,
                             input int burst, input int lastpos,
                             output logic [1:0] resp, output int touched[$]);
        logic        err;
        logic [31:0] a;
        int          idx;
        err = (lastpos != len);
        touched = {};
        for (int k = 0; k <= lastpos; k++) begin
            a   = (burst == 0) ? addr : addr + 32'(k) * (32'd1 << size);
            idx = int'((a >> 2) & 32'(WORDS - 1));
            touched.push_back(idx);
            if (size > 2 || burst > 1 || (a >> (AW + 2)) != (BASE >> (AW + 2))) err = 1'b1;
            else if (k <= len) begin
                for (int b = 0; b < 4; b++) begin
                    if (ts[k][b]) begin
                        mm[idx][8*b +: 8] = td[k][8*b +: 8];
                        known[idx][b]     = 1'b1;
                    end
                end
            end
        end
        resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int lastpos,
                           input bit w_first, input int skew, input int bdelay);
        logic [1:0] exp_resp;
        int         touched[$];
        int         cyc, beat;
        bit         aw_done, aw_hs, w_hs, busy_viol, held_viol, in_held, did_hold;
        model_txn(addr, len, size, burst, lastpos, exp_resp, touched);
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
        bus.awsize = 3'(size); bus.awburst = 2'(burst);
        cyc = 0; beat = 0; aw_done = 0; busy_viol = 0; held_viol = 0; in_held = 0; did_hold = 0;
        while ((!aw_done || beat <= lastpos) && cyc < 200) begin
            bus.awvalid = !aw_done && (w_first ? (cyc >= skew) : 1'b1);
            bus.wvalid  = (beat <= lastpos) && (w_first ? 1'b1 : (cyc >= skew));
            bus.wdata   = td[beat[3:0]];
            bus.wstrb   = ts[beat[3:0]];
            bus.wlast   = (beat == lastpos);
            @(negedge clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            if (aw_done && bus.awready) busy_viol = 1;
            if (in_held && bus.wready) held_viol = 1;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) beat++;
            in_held = (beat > 0) && !aw_done;
            if (in_held) did_hold = 1;
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("handshake_budget", 32'(cyc < 200), 32'd1);
        check("b_latency", 32'(bus.bvalid), 32'd1);
        if (did_hold) check("wready_in_held", 32'(held_viol), 32'd0);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bus.bvalid), 32'd1);
            check("bid_hold", 32'(bus.bid), 32'(id));
            check("bresp_hold", 32'(bus.bresp), 32'(exp_resp));
            if (bus.awready) busy_viol = 1;
            @(posedge clk); #1;
        end
        bus.bready = 1'b1;
        @(negedge clk);
        check("bvalid", 32'(bus.bvalid), 32'd1);
        check("bid", 32'(bus.bid), 32'(id));
        check("bresp", 32'(bus.bresp), 32'(exp_resp));
        if (bus.awready) busy_viol = 1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        check("bvalid_drop", 32'(bus.bvalid), 32'd0);
        check("awready_after_b", 32'(bus.awready), 32'd1);
        check("awready_busy", 32'(busy_viol), 32'd0);
        check_words(touched);
    endtask

    task automatic single(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] d,
                          input logic [3:0] s, input bit w_first, input int skew);
        td[0] = d; ts[0] = s;
        run_txn(id, addr, 0, 2, 1, 0, w_first, skew, 0);
    endtask

    initial begin
        int  n, len, size, burst, lastpos, r;
        bit  hs, bad;
        logic [31:0] addr;
        for (int i = 0; i < WORDS; i++) known[i] = 4'h0;
        bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_wready", 32'(bus.wready), 32'd0);
        check("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("rst_bid", 32'(bus.bid), 32'd0);
        check("rst_bresp", 32'(bus.bresp), 32'd0);
        resetn = 1'b1;
        n = 0;
        while (!bus.awready && n < 10) begin @(posedge clk); #1; n++; end
        check("idle_awready", 32'(bus.awready), 32'd1);

        // Preload words used by directed error/overlay cases
        single(4'h0, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0, 0);
        single(4'h0, 32'h0000_0020, 32'hAAAA_AAAA, 4'hF, 0, 0);
        single(4'h0, 32'h0000_0090, 32'h5555_5555, 4'hF, 0, 0);

        single(4'h1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
        dbg_addr = 10'd4; #1;
        check("word4", dbg_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        single(4'h2, 32'h0000_0020, 32'h1234_5678, 4'h3, 1, 3);
        dbg_addr = 10'd8; #1;
        check("word8", dbg_rdata, 32'hAAAA_5678);
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin td[k] = 32'(k + 1); ts[k] = 4'hF; end
        run_txn(4'h3, 32'h0000_0040, 3, 2, 1, 3, 0, 0, 5);
        single(4'h4, BASE + 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 0, 0);
        td[0] = 32'h7777_7777; ts[0] = 4'hF;
        run_txn(4'h5, 32'h0000_0060, 0, 2, 2, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin td[k] = 32'hC0DE_0000 + 32'(k); ts[k] = 4'hF; end
        run_txn(4'h6, 32'h0000_0070, 2, 2, 1, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin td[k] = 32'hF1F0_0000 + 32'(k); ts[k] = 4'hF; end
        run_txn(4'h7, 32'h0000_0090, 0, 2, 0, 2, 0, 0, 0);

        // Reset in the middle of a 4-beat burst
        bus.awid = 4'h9; bus.awaddr = 32'h0000_00A0; bus.awlen = 8'd3;
        bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.wdata = 32'hCAFE_0001; bus.wstrb = 4'hF; bus.wlast = 1'b0;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        n = 0; hs = 0;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = bus.awready && bus.wready;
            @(posedge clk); #1;
            n++;
        end
        check("rst_setup_hs", 32'(hs), 32'd1);
        mm[40] = 32'hCAFE_0001; known[40] = 4'hF;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        check("midrst_awready", 32'(bus.awready), 32'd0);
        check("midrst_wready", 32'(bus.wready), 32'd0);
        check("midrst_bvalid", 32'(bus.bvalid), 32'd0);
        resetn = 1'b1;
        n = 0; bad = 0;
        while (!bus.awready && n < 10) begin
            if (bus.bvalid) bad = 1;
            @(posedge clk); #1; n++;
        end
        check("midrst_idle", 32'(bus.awready), 32'd1);
        repeat (3) begin
            if (bus.bvalid) bad = 1;
            @(posedge clk); #1;
        end
        check("midrst_no_b", 32'(bad), 32'd0);
        check_words('{40});

        for (int t = 0; t < 40; t++) begin
            len = $urandom_range(0, 5);
            r = $urandom_range(0, 9);
            size  = (r < 7) ? 2 : (r == 7) ? $urandom_range(0, 1) : $urandom_range(3, 7);
            r = $urandom_range(0, 9);
            burst = (r < 8) ? $urandom_range(0, 1) : $urandom_range(2, 3);
            addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom)
                                                : BASE + (32'($urandom_range(0, WORDS - 1)) << 2);
            r = $urandom_range(0, 7);
            if (r == 0 && len > 0) lastpos = $urandom_range(0, len - 1);
            else if (r == 1) lastpos = len + $urandom_range(1, 2);
            else lastpos = len;
            for (int k = 0; k < 16; k++) begin td[k] = $urandom; ts[k] = 4'($urandom); end
            run_txn(4'($urandom), addr, len, size, burst, lastpos,
                    bit'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
